// File: rtl/axil_protocol_monitor_if.sv
// AXI4-Lite bus bundle: master/slave views for agents, a read-only view for passive observers.
interface axil_protocol_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport monitor (
        input awaddr, awprot, awvalid, awready,
        input wdata, wstrb, wvalid, wready,
        input bresp, bvalid, bready,
        input araddr, arprot, arvalid, arready,
        input rdata, rresp, rvalid, rready
    );
endinterface

// File: rtl/axil_protocol_monitor.sv
// Passive AXI4-Lite checker: stall stability, orphan responses, outstanding overflow and
// response timeouts, reported through sticky error flags with a first-error capture.
module axil_protocol_monitor #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    axil_protocol_monitor_if.monitor             s_axil,
    input  logic                                 err_clear,
    output logic [11:0]                          err_flags,
    output logic                                 err_pulse,
    output logic [3:0]                           err_first_id,
    output logic                                 err_first_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int AP = ADDR_WIDTH + 3;
    localparam int WP = DATA_WIDTH + STRB_WIDTH;
    localparam int RP = DATA_WIDTH + 2;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    // Simultaneous increment and decrement leave the count unchanged, also at the limits.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc, input logic dec);
        logic [CW-1:0] n;
        if (inc && !dec && (c != CNT_MAX)) begin
            n = c + CW'(1);
        end else if (dec && !inc && (c != CNT_ZERO)) begin
            n = c - CW'(1);
        end else begin
            n = c;
        end
        return n;
    endfunction

    function automatic logic [TW-1:0] tmr_next(input logic [TW-1:0] t, input logic run);
        logic [TW-1:0] n;
        if (!run || (TIMEOUT == 0)) begin
            n = {TW{1'b0}};
        end else if (t != TMR_MAX) begin
            n = t + TW'(1);
        end else begin
            n = t;
        end
        return n;
    endfunction

    function automatic logic [3:0] first_bit(input logic [11:0] v);
        logic [3:0] id;
        id = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            id = v[i] ? 4'(i) : id;
        end
        return id;
    endfunction

    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [AP-1:0] w_aw_pl, w_ar_pl;
    logic [WP-1:0] w_w_pl;
    logic [1:0]    w_b_pl;
    logic [RP-1:0] w_r_pl;
    logic          w_rd_run, w_wr_run;
    logic [11:0]   w_err;

    logic          r_aw_hv, r_aw_hr, r_w_hv, r_w_hr, r_b_hv, r_b_hr;
    logic          r_ar_hv, r_ar_hr, r_r_hv, r_r_hr;
    logic [AP-1:0] r_aw_pl, r_ar_pl;
    logic [WP-1:0] r_w_pl;
    logic [1:0]    r_b_pl;
    logic [RP-1:0] r_r_pl;
    logic [CW-1:0] r_aw_cnt, r_w_cnt, r_ar_cnt;
    logic [TW-1:0] r_rd_tmr, r_wr_tmr;
    logic          r_boot;
    logic [11:0]   r_err_flags;
    logic          r_err_pulse;
    logic [3:0]    r_first_id;
    logic          r_first_valid;

    assign w_aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_w_hs  = s_axil.wvalid  && s_axil.wready;
    assign w_b_hs  = s_axil.bvalid  && s_axil.bready;
    assign w_ar_hs = s_axil.arvalid && s_axil.arready;
    assign w_r_hs  = s_axil.rvalid  && s_axil.rready;

    assign w_aw_pl = {s_axil.awaddr, s_axil.awprot};
    assign w_w_pl  = {s_axil.wdata, s_axil.wstrb};
    assign w_b_pl  = s_axil.bresp;
    assign w_ar_pl = {s_axil.araddr, s_axil.arprot};
    assign w_r_pl  = {s_axil.rdata, s_axil.rresp};

    assign w_rd_run = (r_ar_cnt != CNT_ZERO) && !w_r_hs;
    assign w_wr_run = (r_aw_cnt != CNT_ZERO) && (r_w_cnt != CNT_ZERO) && !w_b_hs;

    // Per-check failure vector for the current edge; counts and timers are pre-edge values.
    always_comb begin
        w_err     = 12'd0;
        w_err[0]  = r_aw_hv && !r_aw_hr && (!s_axil.awvalid || (w_aw_pl != r_aw_pl));
        w_err[1]  = r_w_hv  && !r_w_hr  && (!s_axil.wvalid  || (w_w_pl  != r_w_pl));
        w_err[2]  = r_b_hv  && !r_b_hr  && (!s_axil.bvalid  || (w_b_pl  != r_b_pl));
        w_err[3]  = r_ar_hv && !r_ar_hr && (!s_axil.arvalid || (w_ar_pl != r_ar_pl));
        w_err[4]  = r_r_hv  && !r_r_hr  && (!s_axil.rvalid  || (w_r_pl  != r_r_pl));
        w_err[5]  = w_r_hs && (r_ar_cnt == CNT_ZERO);
        w_err[6]  = w_b_hs && ((r_aw_cnt == CNT_ZERO) || (r_w_cnt == CNT_ZERO));
        w_err[7]  = (w_aw_hs && !w_b_hs && (r_aw_cnt == CNT_MAX)) ||
                    (w_w_hs  && !w_b_hs && (r_w_cnt  == CNT_MAX)) ||
                    (w_ar_hs && !w_r_hs && (r_ar_cnt == CNT_MAX));
        w_err[8]  = r_boot && (s_axil.rvalid || s_axil.bvalid);
        w_err[9]  = (TIMEOUT != 0) && w_rd_run && (r_rd_tmr == TMR_LAST);
        w_err[10] = (TIMEOUT != 0) && w_wr_run && (r_wr_tmr == TMR_LAST);
        w_err[11] = w_w_hs && (s_axil.wstrb == {STRB_WIDTH{1'b0}});
    end

    // Channel history: last-cycle VALID, READY and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_aw_hv, r_aw_hr, r_w_hv, r_w_hr, r_b_hv, r_b_hr} <= 6'd0;
            {r_ar_hv, r_ar_hr, r_r_hv, r_r_hr}                 <= 4'd0;
            r_aw_pl <= {AP{1'b0}};
            r_w_pl  <= {WP{1'b0}};
            r_b_pl  <= 2'd0;
            r_ar_pl <= {AP{1'b0}};
            r_r_pl  <= {RP{1'b0}};
        end else begin
            {r_aw_hv, r_aw_hr} <= {s_axil.awvalid, s_axil.awready};
            {r_w_hv, r_w_hr}   <= {s_axil.wvalid, s_axil.wready};
            {r_b_hv, r_b_hr}   <= {s_axil.bvalid, s_axil.bready};
            {r_ar_hv, r_ar_hr} <= {s_axil.arvalid, s_axil.arready};
            {r_r_hv, r_r_hr}   <= {s_axil.rvalid, s_axil.rready};
            r_aw_pl <= w_aw_pl;
            r_w_pl  <= w_w_pl;
            r_b_pl  <= w_b_pl;
            r_ar_pl <= w_ar_pl;
            r_r_pl  <= w_r_pl;
        end
    end

    // Outstanding counters, response timers and the first-edge-after-reset marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_cnt <= CNT_ZERO;
            r_w_cnt  <= CNT_ZERO;
            r_ar_cnt <= CNT_ZERO;
            r_rd_tmr <= {TW{1'b0}};
            r_wr_tmr <= {TW{1'b0}};
            r_boot   <= 1'b1;
        end else begin
            r_aw_cnt <= cnt_next(r_aw_cnt, w_aw_hs, w_b_hs);
            r_w_cnt  <= cnt_next(r_w_cnt, w_w_hs, w_b_hs);
            r_ar_cnt <= cnt_next(r_ar_cnt, w_ar_hs, w_r_hs);
            r_rd_tmr <= tmr_next(r_rd_tmr, w_rd_run);
            r_wr_tmr <= tmr_next(r_wr_tmr, w_wr_run);
            r_boot   <= 1'b0;
        end
    end

    // Sticky error state; a failure on the clearing edge survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flags   <= 12'd0;
            r_err_pulse   <= 1'b0;
            r_first_id    <= 4'd0;
            r_first_valid <= 1'b0;
        end else begin
            r_err_pulse <= |w_err;
            if (err_clear) begin
                r_err_flags   <= w_err;
                r_first_valid <= |w_err;
                r_first_id    <= first_bit(w_err);
            end else begin
                r_err_flags <= r_err_flags | w_err;
                if (!r_first_valid && (|w_err)) begin
                    r_first_valid <= 1'b1;
                    r_first_id    <= first_bit(w_err);
                end else begin
                    r_first_valid <= r_first_valid;
                    r_first_id    <= r_first_id;
                end
            end
        end
    end

    assign err_flags       = r_err_flags;
    assign err_pulse       = r_err_pulse;
    assign err_first_id    = r_first_id;
    assign err_first_valid = r_first_valid;
    assign rd_outstanding  = r_ar_cnt;
    assign wr_outstanding  = r_aw_cnt;
endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Self-checking bench for axil_protocol_monitor: read-channel vector table, multi-cycle
// write/clear/reset sequences, then random traffic against a behavioural model.
module tb_axil_protocol_monitor;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int SW   = 4;
    localparam int MAXO = 2;
    localparam int TO   = 8;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clear = 1'b0;
    logic [11:0]   err_flags;
    logic          err_pulse;
    logic [3:0]    err_first_id;
    logic          err_first_valid;
    logic [CW-1:0] rd_outstanding;
    logic [CW-1:0] wr_outstanding;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    axil_protocol_monitor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    axil_protocol_monitor #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axil(bus), .err_clear(err_clear),
        .err_flags(err_flags), .err_pulse(err_pulse), .err_first_id(err_first_id),
        .err_first_valid(err_first_valid), .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding)
    );

    typedef struct packed {
        logic awvalid; logic awready; logic [AW-1:0] awaddr; logic [2:0] awprot;
        logic wvalid;  logic wready;  logic [DW-1:0] wdata;  logic [SW-1:0] wstrb;
        logic bvalid;  logic bready;  logic [1:0] bresp;
        logic arvalid; logic arready; logic [AW-1:0] araddr; logic [2:0] arprot;
        logic rvalid;  logic rready;  logic [DW-1:0] rdata;  logic [1:0] rresp;
    } bus_t;

    typedef struct {
        logic ar_v; logic ar_r; logic [AW-1:0] ar_a;
        logic r_v;  logic r_r;  logic [DW-1:0] r_d;
        logic clr;
        logic [11:0] e_flags; logic e_pulse; logic [3:0] e_id; int e_rd;
    } vec_t;

    vec_t vecs[21];
    bus_t b;

    task automatic drive(input bus_t v);
        bus.awaddr = v.awaddr; bus.awprot = v.awprot; bus.awvalid = v.awvalid; bus.awready = v.awready;
        bus.wdata  = v.wdata;  bus.wstrb  = v.wstrb;  bus.wvalid  = v.wvalid;  bus.wready  = v.wready;
        bus.bresp  = v.bresp;  bus.bvalid = v.bvalid; bus.bready  = v.bready;
        bus.araddr = v.araddr; bus.arprot = v.arprot; bus.arvalid = v.arvalid; bus.arready = v.arready;
        bus.rdata  = v.rdata;  bus.rresp  = v.rresp;  bus.rvalid  = v.rvalid;  bus.rready  = v.rready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] f, input logic p, input logic [3:0] id,
                             input logic fv, input int rd, input int wr);
        check({tag, " flags"}, 32'(err_flags), 32'(f));
        check({tag, " pulse"}, 32'(err_pulse), 32'(p));
        check({tag, " first_id"}, 32'(err_first_id), 32'(id));
        check({tag, " first_valid"}, 32'(err_first_valid), 32'(fv));
        check({tag, " rd_out"}, 32'(rd_outstanding), 32'(rd));
        check({tag, " wr_out"}, 32'(wr_outstanding), 32'(wr));
    endtask

    // ---------------- behavioural reference model (integer counts, previous-cycle snapshot)
    int          m_aw, m_w, m_ar, m_rd_wait, m_wr_wait;
    bit          m_first;
    bus_t        m_prev;
    logic [11:0] m_flags;
    logic        m_pulse, m_fv;
    logic [3:0]  m_id;

    task automatic model_reset();
        m_aw = 0; m_w = 0; m_ar = 0; m_rd_wait = 0; m_wr_wait = 0;
        m_first = 1'b1; m_prev = '0;
        m_flags = 12'd0; m_pulse = 1'b0; m_fv = 1'b0; m_id = 4'd0;
    endtask

    function automatic int upd(input int n, input bit inc, input bit dec);
        if (inc && !dec) return (n < MAXO) ? n + 1 : n;
        if (dec && !inc) return (n > 0) ? n - 1 : n;
        return n;
    endfunction

    function automatic logic [3:0] lowest(input logic [11:0] e);
        for (int i = 0; i < 12; i++) if (e[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_edge(input bus_t c, input logic clr);
        logic [11:0] e;
        bit awhs, whs, bhs, arhs, rhs;
        awhs = c.awvalid && c.awready; whs = c.wvalid && c.wready; bhs = c.bvalid && c.bready;
        arhs = c.arvalid && c.arready; rhs = c.rvalid && c.rready;
        e = 12'd0;
        e[0] = m_prev.awvalid && !m_prev.awready &&
               !(c.awvalid && c.awaddr == m_prev.awaddr && c.awprot == m_prev.awprot);
        e[1] = m_prev.wvalid && !m_prev.wready &&
               !(c.wvalid && c.wdata == m_prev.wdata && c.wstrb == m_prev.wstrb);
        e[2] = m_prev.bvalid && !m_prev.bready && !(c.bvalid && c.bresp == m_prev.bresp);
        e[3] = m_prev.arvalid && !m_prev.arready &&
               !(c.arvalid && c.araddr == m_prev.araddr && c.arprot == m_prev.arprot);
        e[4] = m_prev.rvalid && !m_prev.rready &&
               !(c.rvalid && c.rdata == m_prev.rdata && c.rresp == m_prev.rresp);
        e[5] = rhs && m_ar == 0;
        e[6] = bhs && (m_aw == 0 || m_w == 0);
        e[7] = (awhs && !bhs && m_aw == MAXO) || (whs && !bhs && m_w == MAXO) || (arhs && !rhs && m_ar == MAXO);
        e[8] = m_first && (c.rvalid || c.bvalid);
        m_rd_wait = (m_ar > 0 && !rhs) ? m_rd_wait + 1 : 0;
        m_wr_wait = (m_aw > 0 && m_w > 0 && !bhs) ? m_wr_wait + 1 : 0;
        e[9]  = (m_rd_wait == TO);
        e[10] = (m_wr_wait == TO);
        e[11] = whs && c.wstrb == 4'd0;
        m_aw = upd(m_aw, awhs, bhs);
        m_w  = upd(m_w, whs, bhs);
        m_ar = upd(m_ar, arhs, rhs);
        m_prev = c; m_first = 1'b0;
        m_pulse = |e;
        if (clr) begin
            m_flags = e; m_fv = |e; m_id = lowest(e);
        end else begin
            m_flags = m_flags | e;
            if (!m_fv && (|e)) begin m_fv = 1'b1; m_id = lowest(e); end
        end
    endtask

    function automatic bit rbit(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic bus_t rand_bus(input bus_t p);
        bus_t v;
        v = '0;
        v.awvalid = rbit(40); v.awready = rbit(50); v.awaddr = AW'($urandom_range(0, 1) * 4); v.awprot = 3'($urandom_range(0, 1));
        v.wvalid  = rbit(40); v.wready  = rbit(50); v.wdata  = DW'($urandom_range(0, 1));     v.wstrb  = 4'($urandom_range(0, 15));
        v.bvalid  = rbit(25); v.bready  = rbit(60); v.bresp  = 2'($urandom_range(0, 1));
        v.arvalid = rbit(40); v.arready = rbit(50); v.araddr = AW'($urandom_range(0, 1) * 4); v.arprot = 3'($urandom_range(0, 1));
        v.rvalid  = rbit(25); v.rready  = rbit(60); v.rdata  = DW'($urandom_range(0, 1));     v.rresp  = 2'($urandom_range(0, 1));
        // Mostly honour stalls so the stability checks see both legal and illegal cases.
        if (p.awvalid && !p.awready && rbit(85)) begin v.awvalid = 1'b1; v.awaddr = p.awaddr; v.awprot = p.awprot; end
        if (p.wvalid && !p.wready && rbit(85))   begin v.wvalid = 1'b1; v.wdata = p.wdata; v.wstrb = p.wstrb; end
        if (p.bvalid && !p.bready && rbit(85))   begin v.bvalid = 1'b1; v.bresp = p.bresp; end
        if (p.arvalid && !p.arready && rbit(85)) begin v.arvalid = 1'b1; v.araddr = p.araddr; v.arprot = p.arprot; end
        if (p.rvalid && !p.rready && rbit(85))   begin v.rvalid = 1'b1; v.rdata = p.rdata; v.rresp = p.rresp; end
        return v;
    endfunction

    initial begin
        bus_t prev_r;
        logic clr_r;

        // {ar_v, ar_r, ar_a, r_v, r_r, r_d, clr, exp flags, exp pulse, exp first_id, exp rd_out}
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0014, 1'b0, 1'b0, 32'h0, 1'b0, 12'h008, 1'b1, 4'd3, 0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0014, 1'b0, 1'b0, 32'h0, 1'b0, 12'h008, 1'b0, 4'd3, 1};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b0, 4'd0, 1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 1'b0, 12'h020, 1'b1, 4'd5, 0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b0, 4'd0, 0};
        vecs[8]  = '{1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 1};
        vecs[9]  = '{1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 2};
        vecs[10] = '{1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 32'h0, 1'b0, 12'h080, 1'b1, 4'd7, 2};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 1'b0, 12'h080, 1'b0, 4'd7, 1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b0, 4'd0, 1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[14] = '{1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b0, 12'h008, 1'b1, 4'd3, 0};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b0, 4'd0, 0};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA, 1'b0, 12'h000, 1'b0, 4'd0, 0};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hB, 1'b0, 12'h010, 1'b1, 4'd4, 0};
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b0, 12'h010, 1'b1, 4'd4, 0};
        vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 12'h000, 1'b0, 4'd0, 0};

        // Reset state
        drive('0);
        #12;
        check_all("reset", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("idle after reset", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);

        // Read-channel vector table
        for (int i = 0; i < 21; i++) begin
            b = '0;
            b.arvalid = vecs[i].ar_v; b.arready = vecs[i].ar_r; b.araddr = vecs[i].ar_a;
            b.rvalid  = vecs[i].r_v;  b.rready  = vecs[i].r_r;  b.rdata  = vecs[i].r_d;
            drive(b);
            err_clear = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_pulse, vecs[i].e_id,
                      vecs[i].e_flags != 12'h000, vecs[i].e_rd, 0);
        end
        err_clear = 1'b0;

        // Write timeout: AW, then W two cycles later; timer counts from the later handshake
        b = '0; b.awvalid = 1'b1; b.awready = 1'b1; b.awaddr = 16'h0040; drive(b); step();
        check("tmo aw wr_out", 32'(wr_outstanding), 32'd1);
        drive('0); step();
        b = '0; b.wvalid = 1'b1; b.wready = 1'b1; b.wstrb = 4'hF; b.wdata = 32'h1234; drive(b); step();
        check("tmo w flags", 32'(err_flags), 32'd0);
        drive('0);
        for (int k = 1; k <= TO; k++) begin
            step();
            check($sformatf("tmo bit10 k=%0d", k), 32'(err_flags[10]), 32'(k == TO));
            check($sformatf("tmo pulse k=%0d", k), 32'(err_pulse), 32'(k == TO));
        end
        check("tmo first_id", 32'(err_first_id), 32'd10);
        b = '0; b.bvalid = 1'b1; b.bready = 1'b1; drive(b); step();
        check_all("tmo late B", 12'h400, 1'b0, 4'd10, 1'b1, 0, 0);
        drive('0); err_clear = 1'b1; step(); err_clear = 1'b0;
        check("tmo clear flags", 32'(err_flags), 32'd0);

        // B on the TIMEOUT-th cycle is on time
        b = '0; b.awvalid = 1'b1; b.awready = 1'b1; b.wvalid = 1'b1; b.wready = 1'b1; b.wstrb = 4'h3;
        drive(b); step();
        drive('0);
        for (int k = 1; k < TO; k++) begin
            step();
            check($sformatf("ontime k=%0d", k), 32'(err_flags), 32'd0);
        end
        b = '0; b.bvalid = 1'b1; b.bready = 1'b1; drive(b); step();
        check_all("ontime B", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);

        // Two stall errors on one edge (W bit 1, R bit 4), then clear with counters kept
        b = '0; b.arvalid = 1'b1; b.arready = 1'b1; b.awvalid = 1'b1; b.awready = 1'b1; drive(b); step();
        b = '0; b.wvalid = 1'b1; b.wdata = 32'h1; b.wstrb = 4'hF; b.rvalid = 1'b1; b.rdata = 32'h1;
        drive(b); step();
        b.wdata = 32'h2; b.rdata = 32'h2; drive(b); step();
        check_all("dual err", 12'h012, 1'b1, 4'd1, 1'b1, 1, 1);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        check_all("dual clear", 12'h000, 1'b0, 4'd0, 1'b0, 1, 1);
        b.wready = 1'b1; b.rready = 1'b1; drive(b); step();
        check_all("dual complete", 12'h000, 1'b0, 4'd0, 1'b0, 0, 1);
        b = '0; b.bvalid = 1'b1; b.bready = 1'b1; drive(b); step();
        check_all("dual B", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);

        // bvalid high on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        b = '0; b.bvalid = 1'b1; drive(b);
        step();
        check_all("boot in reset", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("boot bvalid", 12'h100, 1'b1, 4'd8, 1'b1, 0, 0);
        step();
        check("boot pulse drop", 32'(err_pulse), 32'd0);
        b.arvalid = 1'b1; b.arready = 1'b1; drive(b); step();
        check("boot ar rd_out", 32'(rd_outstanding), 32'd1);

        // Asynchronous reset mid-read
        #2 rst_n = 1'b0;
        #1;
        check_all("async reset", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);
        @(negedge clk);
        drive('0);
        rst_n = 1'b1;
        step();
        check_all("after abandon", 12'h000, 1'b0, 4'd0, 1'b0, 0, 0);

        // Random traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        drive('0);
        err_clear = 1'b0;
        prev_r = '0;
        #10;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            prev_r = rand_bus(prev_r);
            clr_r = ($urandom_range(0, 9) == 0);
            drive(prev_r);
            err_clear = clr_r;
            step();
            model_edge(prev_r, clr_r);
            check_all($sformatf("rand%0d", n), m_flags, m_pulse, m_id, m_fv, m_ar, m_aw);
        end
        err_clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/axil_protocol_monitor.md
# axil_protocol_monitor

Synthesizable, passive AXI4-Lite protocol monitor for the slave port of our AXI-Lite RAM and peripherals. It turns the interface rules the team checks formally into cycle-accurate hardware: VALID/payload stability, response-without-request, outstanding-transaction overflow and response timeouts. Errors are reported through sticky flags, so the block runs in simulation, in FPGA debug builds and as a formal harness. It only observes the bus and never drives it.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 16, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions per direction (≥1)
- TIMEOUT, 256, cycles allowed from request to response; 0 disables timeout checks
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axil_aw{addr,prot,valid,ready}  in  ADDR_WIDTH/3/1/1  monitored write-address channel
- s_axil_w{data,strb,valid,ready}  in  DATA_WIDTH/STRB_WIDTH/1/1  monitored write-data channel
- s_axil_b{resp,valid,ready}  in  2/1/1  monitored write-response channel
- s_axil_ar{addr,prot,valid,ready}  in  ADDR_WIDTH/3/1/1  monitored read-address channel
- s_axil_r{data,resp,valid,ready}  in  DATA_WIDTH/2/1/1  monitored read-data channel
- err_clear  in  1  synchronous clear of the sticky error state
- err_flags  out  12  sticky per-check error bits (see Operation)
- err_pulse  out  1  high for one cycle when any check fails at the previous edge
- err_first_id  out  4  index of the first error flagged since reset/clear
- err_first_valid  out  1  err_first_id is meaningful
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted ARs without R
- wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted AWs without B

## Operation
- Each channel has a registered history of VALID, READY and payload (for AW/AR: addr+prot, W: data+strb, B: resp, R: data+resp). History VALID resets to 0.
- Stall rule, checked at each edge: if the history shows VALID && !READY, the current VALID must be 1 and the current payload must equal the history. Any mismatch sets that channel's bit: 0 AW, 1 W, 2 B, 3 AR, 4 R.
- Counters aw_cnt, w_cnt and ar_cnt increment on their handshake (VALID && READY). B handshake decrements aw_cnt and w_cnt. R handshake decrements ar_cnt.
- Bit 5: R handshake while the registered ar_cnt == 0. Bit 6: B handshake while the registered aw_cnt == 0 or w_cnt == 0. The checks use counts from before the current edge, so a response in the same cycle as its request is an error. On underflow the counter holds at 0.
- Bit 7: a handshake on AW, W or AR while the respective counter == MAX_OUTSTANDING. The counter saturates. A simultaneous increment and decrement nets to zero and is legal at MAX.
- Bit 8: rvalid or bvalid high on the first edge after rst_n deasserts.
- Read timer: counts while ar_cnt > 0 and there is no R handshake. It clears on an R handshake or when ar_cnt == 0. Reaching TIMEOUT sets bit 9 and the timer holds.
- Write timer: same behaviour, running while aw_cnt > 0 && w_cnt > 0 and clearing on a B handshake. Reaching TIMEOUT sets bit 10.
- Bit 11: W handshake while wstrb == 0 (empty write).
- err_first_id latches the lowest-numbered bit failing on the first failing edge. It holds until err_clear.
- err_clear clears err_flags, err_first_valid and err_first_id. If a check fails on the same edge as err_clear, the new error wins. Counters, timers and history are unaffected by err_clear.

## Timing
- Reset (async assert, sync-style release): err_flags=0, err_pulse=0, err_first_id=0, err_first_valid=0, rd_outstanding=0, wr_outstanding=0, all counters and timers 0, history VALID=0.
- A violation sampled at edge N is visible on err_flags and err_pulse after edge N, which is 1 cycle latency. err_pulse drops after edge N+1 unless a new failure occurs.
- rd_outstanding and wr_outstanding reflect handshakes at edge N immediately after edge N.
- Timeout fires after exactly TIMEOUT consecutive counting cycles. A response on the TIMEOUT-th cycle is on time.
- Reset asserted mid-transaction discards all state. No error is flagged for abandoned transactions.

## Test plan
- AR addr=0x10, arready low 3 cycles, araddr changes to 0x14 in cycle 2 -> err_flags[3]=1, err_pulse for 1 cycle, err_first_id=3.
- rvalid with rready=1 while rd_outstanding=0 -> err_flags[5]=1; rd_outstanding stays 0.
- MAX_OUTSTANDING=2: three AR handshakes with no R -> rd_outstanding=2 and err_flags[7]=1. Then one R -> rd_outstanding=1 with no new error.
- TIMEOUT=8: one AW+W accepted, bvalid withheld -> err_flags[10] set exactly 8 cycles after the later handshake. Repeat with B on cycle 8 -> no error.
- Two errors on one edge (bits 1 and 4), then err_clear -> err_first_id=1. After the clear, err_flags=0 and err_first_valid=0, while counters are unchanged.
- Deassert rst_n with bvalid=1 -> err_flags[8]=1. Assert rst_n mid-read -> all outputs return to reset values asynchronously.
